// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, opcode tags, flag bit positions and the
// output-slice state encoding.
package alu_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned OP_WIDTH   = 5;
  localparam int unsigned FLAG_WIDTH = 4;

  localparam logic [OP_WIDTH-1:0] OP_ADD = 5'd0;
  localparam logic [OP_WIDTH-1:0] OP_SUB = 5'd1;
  localparam logic [OP_WIDTH-1:0] OP_AND = 5'd2;
  localparam logic [OP_WIDTH-1:0] OP_OR  = 5'd3;
  localparam logic [OP_WIDTH-1:0] OP_SLL = 5'd4;
  localparam logic [OP_WIDTH-1:0] OP_SRA = 5'd5;

  localparam int unsigned FLAG_NE   = 0;
  localparam int unsigned FLAG_LT   = 1;
  localparam int unsigned FLAG_OVF  = 2;
  localparam int unsigned FLAG_ZERO = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } slice_state_t;

  // Packs the ALU status bits into flag-vector order.
  function automatic logic [FLAG_WIDTH-1:0] make_flags(input logic zero, input logic ovf,
                                                       input logic lt, input logic ne);
    logic [FLAG_WIDTH-1:0] f;
    f            = '0;
    f[FLAG_ZERO] = zero;
    f[FLAG_OVF]  = ovf;
    f[FLAG_LT]   = lt;
    f[FLAG_NE]   = ne;
    return f;
  endfunction

endpackage

// File: rtl/register_en.sv
// Width-parameterised D register with synchronous active-low reset and load enable.
module register_en #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/alu_result_slice.sv
// Registered ALU output stage: 2-entry skid buffer with registered in_ready,
// capturing result, opcode tag and flags (zero derived at capture).
module alu_result_slice #(
  parameter int unsigned DATA_WIDTH = alu_pkg::DATA_WIDTH,
  parameter int unsigned OP_WIDTH   = alu_pkg::OP_WIDTH,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [OP_WIDTH-1:0]   in_op,
  input  logic                  in_ne,
  input  logic                  in_lt,
  input  logic                  in_ovf,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [OP_WIDTH-1:0]   out_op,
  output logic [3:0]            out_flags,
  output logic [CNT_WIDTH-1:0]  result_count
);

  import alu_pkg::*;

  localparam int unsigned ENTRY_WIDTH = DATA_WIDTH + OP_WIDTH + FLAG_WIDTH;

  slice_state_t           state, next_state;
  logic                   in_xfer_c, out_xfer_c;
  logic                   main_en_c, skid_en_c, main_from_skid_c;
  logic [ENTRY_WIDTH-1:0] in_entry_c, main_d_c, main_q, skid_q;

  assign in_xfer_c  = in_valid & in_ready;
  assign out_xfer_c = out_valid & out_ready;

  // Zero flag is frozen with the entry so the output never recomputes it.
  assign in_entry_c = {in_data, in_op, make_flags(~|in_data, in_ovf, in_lt, in_ne)};
  assign main_d_c   = main_from_skid_c ? skid_q : in_entry_c;

  // in_ready/out_valid are registered copies of the next-state decode.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= EMPTY;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      result_count <= '0;
    end else begin
      state     <= next_state;
      in_ready  <= (next_state != FULL);
      out_valid <= (next_state != EMPTY);
      if (in_xfer_c) begin
        result_count <= result_count + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    next_state       = state;
    main_en_c        = 1'b0;
    skid_en_c        = 1'b0;
    main_from_skid_c = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer_c) begin
          main_en_c  = 1'b1;
          next_state = ONE;
        end
      end
      ONE: begin
        case ({in_xfer_c, out_xfer_c})
          2'b11:   main_en_c = 1'b1;
          2'b10: begin
            skid_en_c  = 1'b1;
            next_state = FULL;
          end
          2'b01:   next_state = EMPTY;
          default: next_state = ONE;
        endcase
      end
      FULL: begin
        if (out_xfer_c) begin
          main_en_c        = 1'b1;
          main_from_skid_c = 1'b1;
          next_state       = ONE;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  register_en #(.WIDTH(ENTRY_WIDTH)) u_main (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (main_en_c),
    .d       (main_d_c),
    .q       (main_q)
  );

  register_en #(.WIDTH(ENTRY_WIDTH)) u_skid (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (skid_en_c),
    .d       (in_entry_c),
    .q       (skid_q)
  );

  assign {out_data, out_op, out_flags} = main_q;

endmodule

// File: doc/alu_result_slice.md
Name: alu_result_slice

Overview:
- Registered output stage placed directly downstream of the combinational ALU datapath (bitwise_and_32b, bitwise_or, adder, shifter).
- Captures the selected 32-bit result plus comparison/overflow flags and a derived zero flag.
- Presents them to the writeback consumer through a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a fully registered in_ready, cutting the timing path from consumer back into the ALU.

Parameters:
- DATA_WIDTH, 32, width of ALU result and out_data.
- OP_WIDTH, 5, width of the ALU opcode tag carried alongside each result.
- CNT_WIDTH, 8, width of the accepted-result counter (wraps).

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  ALU result valid this cycle.
- in_ready  output  1  slice can accept; registered.
- in_data  input  DATA_WIDTH  ALU result (e.g. bitwise_and_32b out).
- in_op  input  OP_WIDTH  opcode that produced in_data.
- in_ne  input  1  isNotEqual from ALU.
- in_lt  input  1  isLessThan from ALU.
- in_ovf  input  1  overflow from ALU.
- out_valid  output  1  output holds a valid result.
- out_ready  input  1  consumer accepts this cycle.
- out_data  output  DATA_WIDTH  registered result.
- out_op  output  OP_WIDTH  registered opcode tag.
- out_flags  output  4  {zero, ovf, lt, ne}; zero = (data == 0), computed at capture.
- result_count  output  CNT_WIDTH  number of results accepted on the input side, modulo 2^CNT_WIDTH.

Behaviour:
- Clock and reset: one clock, clock; reset is synchronous and active-low (reset_n sampled on posedge clock).
- Reset (reset_n low at a posedge):
  - state to EMPTY; out_valid=0, out_data=0, out_op=0, out_flags=0, result_count=0.
  - in_ready=0 for every cycle reset_n is low; in_ready=1 on the first cycle after release.
  - Skid contents are discarded.
  - Reset mid-operation drops both entries; no partial output persists.
- Transfer definitions: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- State machine, {EMPTY, ONE, FULL}:
  - EMPTY: out_valid=0, in_ready=1. Input transfer loads the main register; next state ONE.
  - ONE: out_valid=1, in_ready=1.
    - Input and output transfer together: main reloads with the new beat; stay ONE.
    - Input transfer only: beat goes to the skid register; next state FULL.
    - Output transfer only: next state EMPTY.
  - FULL: out_valid=1, in_ready=0.
    - Output transfer moves skid into main; next state ONE.
    - No input transfer is possible in this state.
- Latency: 1 cycle from input transfer to out_valid when the slice is empty. Throughput is 1 result/cycle under continuous out_ready.
- Ordering: strict FIFO; no result is dropped or duplicated.
- Stability: while out_valid=1 and out_ready=0, out_data, out_op and out_flags hold stable.
- Zero flag: evaluated on in_data at capture and stored with the entry, not recomputed at output.
- result_count:
  - Increments by 1 on every input transfer; wraps from 2^CNT_WIDTH-1 to 0.
  - Not affected by output transfers.
- in_valid while in_ready=0: ignored; the upstream source must hold its data.
- in_data values are don't-care when in_valid=0; no X propagates into registers unless a transfer occurs.

Decomposition:
- Shared package alu_pkg:
  - DATA_WIDTH=32 and OP_WIDTH=5.
  - ALU opcode constants: ADD=5'd0, SUB=5'd1, AND=5'd2, OR=5'd3, SLL=5'd4, SRA=5'd5.
  - Flag bit indices: NE=0, LT=1, OVF=2, ZERO=3.
  - Slice state encoding: EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
- One natural sub-module: register_en, a parameterised-width D register with synchronous active-low reset and enable. It is instantiated for the main and skid entries (data+op+flags).

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_data=0, result_count=0 throughout; in_ready=1 on the first cycle after release.
- Single beat: in_data=188899668&1=0, op=AND, out_ready=1 -> next cycle out_valid=1, out_data=0, out_flags[ZERO]=1, result_count=1.
- Backpressure/skid: out_ready=0, send 3678&2569=2568 then a second beat 32'hFFFF_FFFF -> state FULL, in_ready=0, and out_data stays 2568 while out_ready=0. Then out_ready=1 -> 2568 followed by 32'hFFFF_FFFF on consecutive cycles.
- Streaming: 100 back-to-back beats (values 0..99), out_ready=1 -> outputs 0..99 in order, one per cycle, in_ready constantly 1.
- Counter wrap: 256 accepted beats -> result_count returns to 0; the 257th beat gives 1.
- Reset while FULL: fill both entries, pulse reset_n=0 for 1 cycle -> out_valid=0, both entries discarded, no stale beat appears after release.
